// File: rtl/iob_sync_assim_fifo_w_big.sv
// iob_sync_assim_fifo_w_big
//   Single-clock asymmetric FIFO, wide write / narrow read. Every accepted
//   write word is split into RATIO = W_DATA_W/R_DATA_W narrow words. They are
//   read out one per accepted read, least-significant slice first.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   w_en      in   write request (ignored while full)
//   data_in   in   W_DATA_W write word
//   full      out  no room for one more wide word
//   r_en      in   read request (ignored while empty)
//   data_out  out  R_DATA_W registered read data, valid one cycle after accept
//   empty     out  no narrow word stored
//   level     out  occupancy in narrow words
module iob_sync_assim_fifo_w_big #(
    parameter int W_DATA_W = 16,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4,
    localparam int RATIO   = W_DATA_W / R_DATA_W,
    localparam int LR      = $clog2(RATIO),
    localparam int AW      = ADDR_W + LR,
    localparam int LVL_W   = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] data_in,
    output logic                full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] data_out,
    output logic                empty,
    output logic [LVL_W-1:0]    level
);
    localparam int CAP = 2 ** AW;

    logic [R_DATA_W-1:0] r_mem [CAP];
    logic [ADDR_W-1:0]   r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_full;
    logic                r_empty;
    logic [R_DATA_W-1:0] r_data_out;

    logic                w_wr_ok;
    logic                w_rd_ok;
    logic [AW-1:0]       w_wbase;
    logic [LVL_W-1:0]    w_level_nxt;

    // Requests are qualified by the registered flags only, so a read can never
    // see data that is being written at the same edge.
    assign w_wr_ok = w_en & ~r_full;
    assign w_rd_ok = r_en & ~r_empty;

    // Narrow-word address of slice 0 of the current wide slot, i.e. {wptr, 0}.
    // Shifting instead of concatenating keeps RATIO = 1 legal (no zero-width
    // slice index).
    assign w_wbase = AW'(r_wptr) << LR;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_ok) w_level_nxt = w_level_nxt + LVL_W'(RATIO);
        if (w_rd_ok) w_level_nxt = w_level_nxt - LVL_W'(1);
    end

    // Storage is not cleared by reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            for (int i = 0; i < RATIO; i++) begin
                r_mem[w_wbase + AW'(i)] <= data_in[i*R_DATA_W +: R_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + ADDR_W'(1);
            if (w_rd_ok) begin
                r_rptr     <= r_rptr + AW'(1);
                r_data_out <= r_mem[r_rptr];
            end
            r_level <= w_level_nxt;
            // Flags come from the next level so they line up with level.
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt > LVL_W'(CAP - RATIO));
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_iob_sync_assim_fifo_w_big.sv
module tb_iob_sync_assim_fifo_w_big;
    localparam int W_DATA_W = 16;
    localparam int R_DATA_W = 8;
    localparam int ADDR_W   = 2;
    localparam int RATIO    = W_DATA_W / R_DATA_W;
    localparam int CAP      = 8;
    localparam int LVL_W    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                w_en = 1'b0;
    logic [W_DATA_W-1:0] data_in = '0;
    logic                full;
    logic                r_en = 1'b0;
    logic [R_DATA_W-1:0] data_out;
    logic                empty;
    logic [LVL_W-1:0]    level;

    int n_tests = 0;
    int n_fail  = 0;

    iob_sync_assim_fifo_w_big #(
        .W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .full(full),
        .r_en(r_en), .data_out(data_out), .empty(empty), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of bytes plus the last byte read.
    byte unsigned mq[$];
    byte unsigned m_dout = 8'h00;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        bit wr, rd;
        if (rst) begin
            mq.delete();
            m_dout = 8'h00;
        end else begin
            wr = w_en && !(mq.size() > CAP - RATIO);
            rd = r_en && (mq.size() != 0);
            if (rd) m_dout = mq.pop_front();
            if (wr) for (int i = 0; i < RATIO; i++) mq.push_back(data_in[i*8 +: 8]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (level != LVL_W'(mq.size()) || empty != (mq.size() == 0) ||
                full != (mq.size() > CAP - RATIO) || data_out != m_dout) begin
                n_fail++;
                $display("FAIL model t=%0t: got lvl=%0d e=%0b f=%0b do=%02h, want lvl=%0d e=%0b f=%0b do=%02h",
                         $time, level, empty, full, data_out, mq.size(),
                         mq.size() == 0, mq.size() > CAP - RATIO, m_dout);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present inputs, let one rising edge take them, return 1 time unit later.
    task automatic drive(input bit rs, input bit w, input logic [15:0] d, input bit r);
        rst = rs; w_en = w; data_in = d; r_en = r;
        @(posedge clk); #1;
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    byte unsigned exp_s[$];
    byte unsigned got_s[$];

    initial begin
        // 1. reset with requests active
        drive(1, 1, 16'h5A5A, 1);
        drive(1, 1, 16'h5A5A, 1);
        chk_en = 1'b1;
        drive(0, 0, 16'h0, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_level", level, 0);
        chk("rst_dout",  data_out, 8'h00);

        // 2. unpack order
        drive(0, 1, 16'hBBAA, 0);
        chk("unpack_lvl2", level, 2);
        drive(0, 0, 16'h0, 1);
        chk("unpack_rd0", data_out, 8'hAA);
        chk("unpack_lvl1", level, 1);
        drive(0, 0, 16'h0, 1);
        chk("unpack_rd1", data_out, 8'hBB);
        chk("unpack_lvl0", level, 0);
        chk("unpack_empty", empty, 1);

        // 3. fill and overflow
        drive(0, 1, 16'h1100, 0);
        drive(0, 1, 16'h3322, 0);
        drive(0, 1, 16'h5544, 0);
        drive(0, 1, 16'h7766, 0);
        chk("fill_full", full, 1);
        chk("fill_lvl", level, 8);
        drive(0, 1, 16'hFFEE, 0);
        chk("ovf_lvl", level, 8);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 16'h0, 1);
            chk($sformatf("drain_%0d", i), data_out, i * 8'h11);
        end
        chk("drain_empty", empty, 1);

        // 4. underflow
        drive(0, 0, 16'h0, 1);
        chk("udf_lvl", level, 0);
        chk("udf_dout", data_out, 8'h77);

        // 5. simultaneous read and write
        drive(0, 1, 16'h0201, 0);
        drive(0, 1, 16'h0403, 0);
        drive(0, 0, 16'h0, 1);
        chk("sim_lvl3", level, 3);
        drive(0, 1, 16'h0605, 1);
        chk("sim_lvl4", level, 4);
        drive(0, 0, 16'h0, 1);
        drive(0, 1, 16'h0807, 0);
        drive(0, 1, 16'h0A09, 0);
        chk("sim_lvl7", level, 7);
        chk("sim_full7", full, 1);
        drive(0, 1, 16'hDEAD, 1);
        chk("sim_full_rw_lvl", level, 6);
        while (!empty) drive(0, 0, 16'h0, 1);

        // 6. wrap-around, level kept in 2..3
        exp_s.delete(); got_s.delete();
        for (int k = 0; k < 20; k++) begin
            logic [15:0] wd;
            wd = 16'((k * 16'h1357) ^ 16'hA5C3);
            exp_s.push_back(wd[7:0]);
            exp_s.push_back(wd[15:8]);
            if (k == 0) drive(0, 1, wd, 0);
            else begin
                drive(0, 1, wd, 1);
                got_s.push_back(data_out);
                drive(0, 0, 16'h0, 1);
                got_s.push_back(data_out);
            end
        end
        for (int g = 0; g < 16 && !empty; g++) begin
            drive(0, 0, 16'h0, 1);
            got_s.push_back(data_out);
        end
        chk("wrap_count", got_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
            if (got_s[i] != exp_s[i]) chk($sformatf("wrap_b%0d", i), got_s[i], exp_s[i]);
        n_tests++;

        // 7. mid-stream reset
        drive(0, 1, 16'h1111, 0);
        drive(0, 1, 16'h2222, 0);
        drive(0, 1, 16'h3333, 0);
        drive(0, 0, 16'h0, 1);
        chk("mrst_lvl5", level, 5);
        drive(1, 1, 16'h9999, 0);
        chk("mrst_lvl0", level, 0);
        chk("mrst_empty", empty, 1);
        drive(0, 1, 16'hCDAB, 0);
        drive(0, 0, 16'h0, 1);
        chk("mrst_rd", data_out, 8'hAB);
        drive(0, 0, 16'h0, 1);
        chk("mrst_rd2", data_out, 8'hCD);
        drive(0, 0, 16'h0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
